// File: rtl/logic_unit_pkg.sv
// Shared types for the pipelined bitwise logic unit: op encoding and accumulator FSM state.
package logic_unit_pkg;

   localparam int unsigned OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_AND  = 3'b000,
      OP_OR   = 3'b001,
      OP_XOR  = 3'b010,
      OP_NOR  = 3'b011,
      OP_NAND = 3'b100,
      OP_XNOR = 3'b101,
      OP_PASS = 3'b110,
      OP_NOT  = 3'b111
   } op_e;

   typedef enum logic {
      ACC_IDLE = 1'b0,
      ACC_RUN  = 1'b1
   } acc_state_e;

endpackage

// File: rtl/logic_op_core.sv
// Combinational bitwise op with legacy enable gating (en=0 forces a zero result).
module logic_op_core
   import logic_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic              en,
   input  logic [OP_W-1:0]   op,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   output logic [WIDTH-1:0]  f_c
);

   always_comb begin
      f_c = '0;
      if (en) begin
         case (op_e'(op))
            OP_AND:  f_c = a & b;
            OP_OR:   f_c = a | b;
            OP_XOR:  f_c = a ^ b;
            OP_NOR:  f_c = ~(a | b);
            OP_NAND: f_c = ~(a & b);
            OP_XNOR: f_c = ~(a ^ b);
            OP_PASS: f_c = a;
            OP_NOT:  f_c = ~a;
            default: f_c = '0;
         endcase
      end
   end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic unit with registered flags and optional OR-accumulate.
module logic_unit_pipe
   import logic_unit_pkg::*;
#(
   parameter int unsigned WIDTH      = 4,
   parameter bit          ACC_ENABLE = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              en,
   input  logic [OP_W-1:0]   op,
   input  logic              acc,
   input  logic              last,
   input  logic [WIDTH-1:0]  rd1,
   input  logic [WIDTH-1:0]  rd2,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  result,
   output logic              zero,
   output logic              parity
);

   logic              s1_valid;
   logic [WIDTH-1:0]  s1_rd1, s1_rd2;
   logic [OP_W-1:0]   s1_op;
   logic              s1_en, s1_acc, s1_last;
   logic              adv2, xfer;
   logic [WIDTH-1:0]  f_c, res_c;

   assign adv2     = !out_valid || out_ready;
   assign in_ready = !s1_valid || adv2;
   assign xfer     = s1_valid && adv2;

   // Stage 1: operand/control capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_rd1   <= '0;
         s1_rd2   <= '0;
         s1_op    <= '0;
         s1_en    <= 1'b0;
         s1_acc   <= 1'b0;
         s1_last  <= 1'b0;
      end else begin
         if (in_ready) s1_valid <= in_valid;
         if (in_valid && in_ready) begin
            s1_rd1  <= rd1;
            s1_rd2  <= rd2;
            s1_op   <= op;
            s1_en   <= en;
            s1_acc  <= acc;
            s1_last <= last;
         end
      end
   end

   logic_op_core #(.WIDTH(WIDTH)) u_core (
      .en  (s1_en),
      .op  (s1_op),
      .a   (s1_rd1),
      .b   (s1_rd2),
      .f_c (f_c)
   );

   if (ACC_ENABLE) begin : g_acc
      acc_state_e       state_q, state_d;
      logic [WIDTH-1:0] acc_q, acc_d;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q <= ACC_IDLE;
            acc_q   <= '0;
         end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
         end
      end

      // Result merge is combinational; state only moves when the beat leaves S1
      always_comb begin
         state_d = state_q;
         acc_d   = acc_q;
         res_c   = f_c;
         if (s1_acc && state_q == ACC_RUN) res_c = acc_q | f_c;
         if (xfer && s1_acc) begin
            case (state_q)
               ACC_IDLE: begin
                  if (!s1_last) begin
                     acc_d   = f_c;
                     state_d = ACC_RUN;
                  end
               end
               ACC_RUN: begin
                  if (s1_last) begin
                     acc_d   = '0;
                     state_d = ACC_IDLE;
                  end else begin
                     acc_d   = acc_q | f_c;
                  end
               end
               default: state_d = ACC_IDLE;
            endcase
         end
      end
   end else begin : g_noacc
      logic unused_acc_ctl;
      assign unused_acc_ctl = s1_acc ^ s1_last;
      assign res_c          = f_c;
   end

   // Stage 2: result and flags, held while downstream stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         result    <= '0;
         zero      <= 1'b0;
         parity    <= 1'b0;
      end else if (adv2) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            result <= res_c;
            zero   <= (res_c == '0);
            parity <= ^res_c;
         end
      end
   end

endmodule
